// File: rtl/hilo_acc_unit.sv
// HI/LO special-register unit with a one-entry pending stage.
// Ops enter the pending stage on one edge and commit to HI/LO on the next.
// hi_fwd/lo_fwd present the post-commit value so MFHI/MFLO see in-flight data.
module hilo_acc_unit #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          op_valid,
    input  logic [2:0]    op_mode,
    input  logic [DW-1:0] hi_i,
    input  logic [DW-1:0] lo_i,
    output logic [DW-1:0] hi_o,
    output logic [DW-1:0] lo_o,
    output logic [DW-1:0] hi_fwd,
    output logic [DW-1:0] lo_fwd,
    output logic          pend_o
);

    localparam logic [2:0] MODE_WR_HI   = 3'b001;
    localparam logic [2:0] MODE_WR_LO   = 3'b010;
    localparam logic [2:0] MODE_WR_BOTH = 3'b011;
    localparam logic [2:0] MODE_ACC_ADD = 3'b100;
    localparam logic [2:0] MODE_ACC_SUB = 3'b101;

    logic [2*DW-1:0] hilo;
    logic [2*DW-1:0] p_data;
    logic [2*DW-1:0] commit_val;
    logic [2*DW-1:0] fwd_val;
    logic [2:0]      p_mode;
    logic            p_valid;
    logic            op_legal;

    // Only modes 001..101 occupy the pending stage; 000/110/111 are NOPs.
    assign op_legal = (op_mode != 3'b000) && (op_mode <= MODE_ACC_SUB);

    // Result the pending op produces against the current HI/LO.
    // The accumulate is a single 2*DW-wide add/sub so carry/borrow
    // crosses from LO into HI naturally.
    always_comb begin
        commit_val = hilo;
        case (p_mode)
            MODE_WR_HI:   commit_val = {p_data[2*DW-1:DW], hilo[DW-1:0]};
            MODE_WR_LO:   commit_val = {hilo[2*DW-1:DW], p_data[DW-1:0]};
            MODE_WR_BOTH: commit_val = p_data;
            MODE_ACC_ADD: commit_val = hilo + p_data;
            MODE_ACC_SUB: commit_val = hilo - p_data;
            default:      commit_val = hilo;
        endcase
    end

    // Forwarded view depends only on registers, never on this cycle's inputs.
    assign fwd_val = p_valid ? commit_val : hilo;

    assign hi_o   = hilo[2*DW-1:DW];
    assign lo_o   = hilo[DW-1:0];
    assign hi_fwd = fwd_val[2*DW-1:DW];
    assign lo_fwd = fwd_val[DW-1:0];
    assign pend_o = p_valid;

    // Capture the new op and commit the previous one on the same edge;
    // reset beats flush, flush drops both pending and incoming ops.
    always_ff @(posedge clk) begin
        if (rst) begin
            hilo    <= '0;
            p_valid <= 1'b0;
            p_mode  <= 3'b000;
            p_data  <= '0;
        end else if (flush) begin
            p_valid <= 1'b0;
        end else begin
            if (p_valid) begin
                hilo <= commit_val;
            end
            p_valid <= op_valid && op_legal;
            p_mode  <= op_mode;
            p_data  <= {hi_i, lo_i};
        end
    end

endmodule

// File: tb/tb_hilo_acc_unit.sv
module tb_hilo_acc_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        op_valid;
    logic [2:0]  op_mode;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] hi_fwd;
    logic [31:0] lo_fwd;
    logic        pend_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] hf;
        logic [31:0] lf;
        logic        pend;
    } exp_t;

    exp_t exp_q[$];

    // reference model state
    logic [63:0] m_arch;
    logic        m_pv;
    logic [2:0]  m_pmode;
    logic [63:0] m_pdata;

    hilo_acc_unit #(.DW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .op_valid (op_valid),
        .op_mode  (op_mode),
        .hi_i     (hi_i),
        .lo_i     (lo_i),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .hi_fwd   (hi_fwd),
        .lo_fwd   (lo_fwd),
        .pend_o   (pend_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] apply_op(input logic [2:0] mode, input logic [63:0] d,
                                             input logic [63:0] cur);
        logic [63:0] r;
        r = cur;
        if (mode == 3'd1)      r[63:32] = d[63:32];
        else if (mode == 3'd2) r[31:0]  = d[31:0];
        else if (mode == 3'd3) r = d;
        else if (mode == 3'd4) r = cur + d;
        else if (mode == 3'd5) r = cur - d;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One cycle: drive at negedge, push model expectation, sample next negedge.
    task automatic step(input logic v, input logic [2:0] m, input logic [31:0] h,
                        input logic [31:0] l, input logic fl, input logic rs);
        exp_t e;
        exp_t got;
        op_valid = v;
        op_mode  = m;
        hi_i     = h;
        lo_i     = l;
        flush    = fl;
        rst      = rs;
        if (rs) begin
            m_arch  = 64'd0;
            m_pv    = 1'b0;
            m_pmode = 3'd0;
            m_pdata = 64'd0;
        end else if (fl) begin
            m_pv = 1'b0;
        end else begin
            if (m_pv) m_arch = apply_op(m_pmode, m_pdata, m_arch);
            m_pv    = v && (m >= 3'd1) && (m <= 3'd5);
            m_pmode = m;
            m_pdata = {h, l};
        end
        e.hi   = m_arch[63:32];
        e.lo   = m_arch[31:0];
        e.pend = m_pv;
        if (m_pv) begin
            e.hf = apply_op(m_pmode, m_pdata, m_arch) >> 32;
            e.lf = apply_op(m_pmode, m_pdata, m_arch) & 64'hFFFF_FFFF;
        end else begin
            e.hf = e.hi;
            e.lf = e.lo;
        end
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
        end else begin
            got = exp_q.pop_front();
            check("sb_arch", {hi_o, lo_o}, {got.hi, got.lo});
            check("sb_fwd", {hi_fwd, lo_fwd}, {got.hf, got.lf});
            check("sb_pend", {63'd0, pend_o}, {63'd0, got.pend});
        end
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; op_valid = 1'b0; op_mode = 3'd0; hi_i = '0; lo_i = '0;
        m_arch = '0; m_pv = 1'b0; m_pmode = '0; m_pdata = '0;
        @(negedge clk);

        // reset
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        check("rst_arch", {hi_o, lo_o}, 64'd0);
        check("rst_fwd", {hi_fwd, lo_fwd}, 64'd0);
        check("rst_pend", {63'd0, pend_o}, 64'd0);

        // WR_BOTH latency
        step(1'b1, 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
        check("wrb_fwd_n1", {hi_fwd, lo_fwd}, 64'h1234_5678_9ABC_DEF0);
        check("wrb_hi_n1", {32'd0, hi_o}, 64'd0);
        check("wrb_pend_n1", {63'd0, pend_o}, 64'd1);
        idle();
        check("wrb_arch_n2", {hi_o, lo_o}, 64'h1234_5678_9ABC_DEF0);

        // carry LO -> HI
        step(1'b1, 3'd3, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle();
        step(1'b1, 3'd4, 32'h0, 32'h1, 1'b0, 1'b0);
        idle();
        check("carry", {hi_o, lo_o}, 64'h0000_0001_0000_0000);

        // borrow wrap-around
        step(1'b1, 3'd3, 32'h0, 32'h0, 1'b0, 1'b0);
        idle();
        step(1'b1, 3'd5, 32'h0, 32'h1, 1'b0, 1'b0);
        idle();
        check("wrap", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFF);

        // back-to-back chain
        step(1'b1, 3'd2, 32'hDEAD_BEEF, 32'd5, 1'b0, 1'b0);
        check("chain_fwd1", {hi_fwd, lo_fwd}, 64'hFFFF_FFFF_0000_0005);
        step(1'b1, 3'd1, 32'd7, 32'hCAFE_F00D, 1'b0, 1'b0);
        check("chain_fwd2", {hi_fwd, lo_fwd}, 64'h0000_0007_0000_0005);
        check("chain_arch2", {hi_o, lo_o}, 64'hFFFF_FFFF_0000_0005);
        step(1'b1, 3'd4, 32'd1, 32'd3, 1'b0, 1'b0);
        check("chain_fwd3", {hi_fwd, lo_fwd}, 64'h0000_0008_0000_0008);
        check("chain_pend3", {63'd0, pend_o}, 64'd1);
        idle();
        check("chain_final", {hi_o, lo_o}, 64'h0000_0008_0000_0008);

        // flush cancels pending and same-cycle op
        step(1'b1, 3'd3, 32'd1, 32'd1, 1'b0, 1'b0);
        idle();
        step(1'b1, 3'd4, 32'd0, 32'h10, 1'b0, 1'b0);
        step(1'b1, 3'd1, 32'd9, 32'd0, 1'b1, 1'b0);
        check("flush_pend", {63'd0, pend_o}, 64'd0);
        check("flush_arch", {hi_o, lo_o}, 64'h0000_0001_0000_0001);
        idle();
        check("flush_hold", {hi_o, lo_o}, 64'h0000_0001_0000_0001);

        // flush with nothing pending
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        check("flush_idle", {hi_o, lo_o}, 64'h0000_0001_0000_0001);

        // rst while pending
        step(1'b1, 3'd4, 32'd0, 32'h10, 1'b0, 1'b0);
        step(1'b1, 3'd1, 32'd9, 32'd0, 1'b0, 1'b1);
        check("rst_pend_arch", {hi_o, lo_o}, 64'd0);
        check("rst_pend_pend", {63'd0, pend_o}, 64'd0);

        // NOP modes do not occupy the pending stage
        step(1'b1, 3'd0, 32'd3, 32'd3, 1'b0, 1'b0);
        check("nop0", {63'd0, pend_o}, 64'd0);
        step(1'b1, 3'd6, 32'd3, 32'd3, 1'b0, 1'b0);
        check("nop6", {63'd0, pend_o}, 64'd0);
        step(1'b1, 3'd7, 32'd3, 32'd3, 1'b0, 1'b0);
        idle();
        check("nop_arch", {hi_o, lo_o}, 64'd0);

        // random stream
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
                 $urandom_range(0, 9) == 0, 1'b0);
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
